// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: operand/product widths and the
// state encoding of the sequential multiplier.
package mac_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_8_bit.sv
// 8-bit ripple-carry adder with carry out; shared with the multiplier's
// per-iteration conditional add.
module adder_8_bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   output logic       carry_out
);

   always_comb begin
      logic carry;
      sum   = '0;
      carry = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      carry_out = carry;
   end

endmodule

// File: rtl/multiplier_8_bit_seq.sv
// Sequential unsigned 8x8 shift-and-add multiplier: one conditional add and
// a 17-bit right shift per clock, valid/ready on both operand and product.
module multiplier_8_bit_seq
   import mac_pkg::*;
#(
   parameter int WIDTH = OP_W,
   parameter int CNT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; the source holds its data stable until that edge.

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mq;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;

   assign addend = mq[0] ? mcand : '0;

   adder_8_bit u_adder (
      .a         (acc),
      .b         (addend),
      .sum       (sum),
      .carry_out (carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (in_valid) next_state = ST_BUSY;
         ST_BUSY: if (cnt == CNT_W'(WIDTH - 1)) next_state = ST_DONE;
         ST_DONE: if (out_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // The carry of each add lands in acc's MSB, so the product never overflows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         mq    <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  mcand <= a;
                  mq    <= b;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            ST_BUSY: begin
               {acc, mq} <= {carry, sum, mq[WIDTH-1:1]};
               cnt       <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign product   = {acc, mq};

endmodule

// File: tb/tb_multiplier_8_bit_seq.sv
// Directed bench for multiplier_8_bit_seq: vector table plus hand-written
// sequences for stall, mid-operation reset and back-to-back operation.
module tb_multiplier_8_bit_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] product;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      int          hold;
      logic [15:0] exp_prod;
   } vec_t;

   vec_t vecs[8];

   multiplier_8_bit_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair, stall hold cycles in DONE, then hand the product off.
   task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                         input int hold, input logic [15:0] exp_prod);
      int lat;
      int busy_low;
      int guard;
      guard = 0;
      while (!in_ready && guard < 30) begin
         tick();
         guard++;
      end
      check("ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      a = va;
      b = vb;
      tick();
      in_valid = 1'b0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      lat = 0;
      busy_low = 1;
      while (!out_valid && lat < 20) begin
         if (in_ready) busy_low = 0;
         a = 8'($urandom_range(0, 255));
         tick();
         lat++;
      end
      check("latency", lat, 8);
      check("in_ready_low_busy", busy_low, 1);
      check("product", {16'd0, product}, {16'd0, exp_prod});
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_product", {16'd0, product}, {16'd0, exp_prod});
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      check("done_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'd13,  8'd11,  0, 16'h008F};
      vecs[1] = '{8'd255, 8'd255, 0, 16'hFE01};
      vecs[2] = '{8'd0,   8'd200, 0, 16'h0000};
      vecs[3] = '{8'd200, 8'd0,   0, 16'h0000};
      vecs[4] = '{8'd7,   8'd9,   5, 16'd63};
      vecs[5] = '{8'd128, 8'd2,   0, 16'd256};
      vecs[6] = '{8'd15,  8'd17,  2, 16'd255};
      vecs[7] = '{8'd1,   8'd255, 0, 16'd255};

      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // out_ready pulsed in IDLE must not disturb anything
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_out_ready_ignored", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_prod);

      // Reset during iteration 4 of 100*100
      in_valid = 1'b1;
      a = 8'd100;
      b = 8'd100;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_busy_in_ready", {31'd0, in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd3, 8'd5, 0, 16'd15);

      // Reset while stalled in DONE
      in_valid = 1'b1;
      a = 8'd9;
      b = 8'd9;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_done_valid", {31'd0, out_valid}, 32'd0);
      check("abort_done_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Back-to-back with in_valid held high and out_ready held high
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a = 8'd2;
      b = 8'd3;
      tick();
      a = 8'd4;
      b = 8'd5;
      for (int i = 0; i < 7; i++) tick();
      check("b2b_not_yet", {31'd0, out_valid}, 32'd0);
      tick();
      check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_first_product", {16'd0, product}, 32'd6);
      tick();
      check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("b2b_second_accept", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      a = 8'd99;
      b = 8'd99;
      for (int i = 0; i < 7; i++) tick();
      check("b2b_second_not_yet", {31'd0, out_valid}, 32'd0);
      tick();
      check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_second_product", {16'd0, product}, 32'd20);
      tick();
      out_ready = 1'b0;
      check("b2b_end_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_end_valid", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
